count_monitor: RTL
==================

COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 Parameter: N, default 8, modulus of the observed counter.
REQ-002 Parameter: WIDTH, default 16, width of the observed count bus.
REQ-003 Parameter: ERRW, default 8, width of the error counter.
REQ-004 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: enable  input  1  increment enable driven to the observed counter.
REQ-007 Port: count  input  WIDTH  observed counter value.
REQ-008 Port: clr_err  input  1  clears err_sticky and err_count.
REQ-009 Port: locked  output  1  high while the monitor is in TRACK.
REQ-010 Port: error  output  1  one-cycle pulse per detected mismatch.
REQ-011 Port: err_sticky  output  1  set on any mismatch, held until clr_err or reset.
REQ-012 Port: err_count  output  ERRW  saturating mismatch count.
REQ-013 Port: wrap_count  output  16  count of verified N-1 -> 0 wraps, modulo 2^16.

Function
REQ-014 At each rising edge, the monitor SHALL sample count and enable as presented before that edge.
REQ-015 Predicted next value pred SHALL be (count+1) mod N when enable=1, otherwise count; computed at WIDTH+1 bits, no truncation before the modulo.
REQ-016 FSM states SHALL be SYNC and TRACK only; reset state is SYNC.
REQ-017 In SYNC: if count < N, expected <= pred and go to TRACK; otherwise stay in SYNC with no error.
REQ-018 In TRACK with count == expected: expected <= pred; stay in TRACK.
REQ-019 In TRACK with count != expected, including count >= N: error = 1 in the following cycle, err_sticky <= 1, err_count increments, go to SYNC.
REQ-020 Re-acquisition after a mismatch SHALL take at least one edge in SYNC; the mismatching sample is never used as a new reference.
REQ-021 err_count SHALL saturate at 2^ERRW-1.
REQ-022 wrap_count SHALL increment when TRACK, count == expected, count == N-1 and enable = 1.
REQ-023 When clr_err = 1 coincides with a mismatch, the clear SHALL apply first: err_sticky = 1 and err_count = 1 afterwards.
REQ-024 clr_err SHALL NOT affect the FSM, expected, locked or wrap_count.
REQ-025 locked SHALL be registered and equal (state == TRACK).
REQ-026 All outputs SHALL be registered with no combinational input-to-output path.

Reset
REQ-027 When reset = 1 at an edge: state = SYNC, expected = 0, and locked, error, err_sticky, err_count and wrap_count = 0.
REQ-028 Reset asserted mid-TRACK SHALL discard the tracked value; it SHALL NOT raise error.
REQ-029 Reset SHALL take priority over clr_err and over all mismatch detection.

Configuration
REQ-030 Macro COUNT_MONITOR_ERRCNT_EN defined: the err_count register and its saturating increment are present.
REQ-031 Macro absent: no err_count register is built and err_count is tied to 0; error and err_sticky behaviour are unchanged.

Structure
REQ-032 Shared package count_monitor_pkg SHALL hold the state enum typedef (SYNC, TRACK) and the default constants for N, WIDTH and ERRW.
REQ-033 Sub-module count_pred SHALL implement the combinational pred function (inputs: count, enable; parameter: N).

Verification
REQ-034 Reset, then enable = 1 with count stepping 0..7,0..7 (N = 8): locked high from the second edge, error never set, wrap_count = 2.
REQ-035 Tracking, then count forced to 5 where 3 is expected: error pulses exactly one cycle, err_sticky = 1, err_count = 1, locked drops, and the monitor re-locks on the next in-range sample.
REQ-036 count = 9 (N = 8) in SYNC: the monitor stays in SYNC with no error; count = 9 in TRACK: mismatch.
REQ-037 enable = 0 for 4 cycles with count held at 6: no error; wrap_count unchanged.
REQ-038 300 forced mismatches with ERRW = 8: err_count = 255; clr_err coincident with a mismatch: err_count = 1, err_sticky = 1.
REQ-039 reset asserted mid-TRACK at count = 4: all outputs 0 after the edge, no error pulse; the run is repeated with COUNT_MONITOR_ERRCNT_EN undefined, and err_count stays 0 throughout.

Source files
------------

// File: rtl/count_monitor_pkg.sv
// count_monitor_pkg
// Shared types and default constants for the count monitor.
//   state_t   : monitor FSM state (SYNC, TRACK)
//   N_DEF     : default modulus of the observed counter
//   WIDTH_DEF : default width of the observed count bus
//   ERRW_DEF  : default width of the saturating error counter
package count_monitor_pkg;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int N_DEF     = 8;
    localparam int WIDTH_DEF = 16;
    localparam int ERRW_DEF  = 8;

endpackage

// File: rtl/count_pred.sv
// count_pred
// Combinational prediction of the observed counter's next value.
// Ports:
//   count  (in,  WIDTH)   : current observed count
//   enable (in,  1)       : increment enable seen by the observed counter
//   pred   (out, WIDTH+1) : (count+1) mod N when enabled, else count
// The result keeps one extra bit so count = 2^WIDTH-1 does not wrap
// before the modulo is taken.
module count_pred #(
    parameter int N     = 8,
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic             enable,
    output logic [WIDTH:0]   pred
);

    logic [WIDTH:0] count_x;
    logic [WIDTH:0] inc;

    assign count_x = {1'b0, count};
    assign inc     = count_x + (WIDTH+1)'(1);

    always_comb begin
        pred = count_x;
        if (enable) begin
            pred = inc % (WIDTH+1)'(N);
        end
    end

endmodule

// File: rtl/count_monitor.sv
// count_monitor
// Watches an external modulo-N counter and checks that every sample
// matches the value predicted from the previous sample.
// Ports:
//   clock      (in)        : sole clock, rising edge
//   reset      (in)        : synchronous active-high reset
//   enable     (in)        : increment enable driven to the observed counter
//   count      (in, WIDTH) : observed counter value
//   clr_err    (in)        : clears err_sticky and err_count
//   locked     (out)       : high while tracking
//   error      (out)       : one-cycle pulse per mismatch
//   err_sticky (out)       : set on mismatch, held until clr_err/reset
//   err_count  (out, ERRW) : saturating mismatch count
//   wrap_count (out, 16)   : verified N-1 -> 0 wraps, modulo 2^16
// Build option: COUNT_MONITOR_ERRCNT_EN builds the err_count register;
// without it err_count is tied to zero.
//
// state | meaning
// SYNC  | no trusted reference; first in-range sample becomes one
// TRACK | each sample must equal the value predicted last edge
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ERRW  = ERRW_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] count,
    input  logic             clr_err,
    output logic             locked,
    output logic             error,
    output logic             err_sticky,
    output logic [ERRW-1:0]  err_count,
    output logic [15:0]      wrap_count
);

    state_t         state, state_nxt;
    logic [WIDTH:0] expected, expected_nxt;
    logic [WIDTH:0] pred;
    logic [WIDTH:0] count_x;
    logic           mismatch;
    logic           wrap_hit;

    assign count_x = {1'b0, count};

    count_pred #(.N(N), .WIDTH(WIDTH)) u_pred (
        .count  (count),
        .enable (enable),
        .pred   (pred)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= SYNC;
            expected <= '0;
        end else begin
            state    <= state_nxt;
            expected <= expected_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        expected_nxt = expected;
        mismatch     = 1'b0;
        wrap_hit     = 1'b0;
        case (state)
            SYNC: begin
                if (count_x < (WIDTH+1)'(N)) begin
                    expected_nxt = pred;
                    state_nxt    = TRACK;
                end
            end
            TRACK: begin
                if (count_x == expected) begin
                    expected_nxt = pred;
                    wrap_hit     = enable && (count_x == (WIDTH+1)'(N-1));
                end else begin
                    // the bad sample is dropped; SYNC picks up the next one
                    mismatch  = 1'b1;
                    state_nxt = SYNC;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            locked     <= 1'b0;
            error      <= 1'b0;
            err_sticky <= 1'b0;
            wrap_count <= '0;
        end else begin
            locked     <= (state_nxt == TRACK);
            error      <= mismatch;
            // clear first, then a coincident mismatch sets it again
            err_sticky <= mismatch | (err_sticky & ~clr_err);
            wrap_count <= wrap_count + 16'(wrap_hit);
        end
    end

`ifdef COUNT_MONITOR_ERRCNT_EN
    logic [ERRW-1:0] err_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (clr_err) begin
            err_cnt_q <= mismatch ? ERRW'(1) : '0;
        end else if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERRW'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule
